pipe_track: RTL and testbench

Parametrised instruction-tracking spine for the in-order RISC-V core. It replaces the fixed IF_ID/ID_EX/EX_MEM/MEM_WB register set with a chain of STAGES slots. Each slot carries valid, instruction, PC and result. The block generalises operand forwarding to arbitrary depth, inserts load-use stalls on its own, and supports partial flushes and per-slot stalls. Datapath logic (ALU, memories, register file) stays outside and reads and writes slots through flat buses.

---
 rtl/pipe_track_pkg.sv | 28 ++
 rtl/pipe_fwd_select.sv | 32 +++
 rtl/pipe_track.sv | 192 +++++++++++++++++++
 tb/tb_pipe_track.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_track_pkg.sv
// Shared constants, opcode decode and the rd-writer predicate for the tracking spine.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package pipe_pkg;

   // Canonical bubble: add x0, x0, x0
   localparam logic [31:0] NOP = 32'h0000_0033;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // True when the instruction produces an architectural register value
   function automatic logic writes_rd(input logic [31:0] instr);
      logic isWriter;
      case (instr[6:0])
         OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JAL,
         OPC_JALR, OPC_LUI, OPC_AUIPC: isWriter = 1'b1;
         default:                      isWriter = 1'b0;
      endcase
      return isWriter && (instr[11:7] != 5'd0);
   endfunction

endpackage

// File: rtl/pipe_fwd_select.sv
// Finds the youngest older in-flight writer of one source register and picks its value.
// Latency: purely combinational.
// Backpressure: none; notReady tells the caller the winning producer has no value yet.
module pipe_fwd_select #(
   parameter int XLEN  = 32,
   parameter int CANDS = 3
) (
   input  logic [4:0]            rs,
   input  logic [CANDS-1:0]      candVld,
   input  logic [CANDS*5-1:0]    candRd,
   input  logic [CANDS*XLEN-1:0] candVal,
   input  logic [CANDS-1:0]      candRdy,
   output logic                  hit,
   output logic [XLEN-1:0]       data,
   output logic                  notReady
);

   // Scan oldest to youngest so the youngest match (index 0) overwrites older ones
   always_comb begin
      hit      = 1'b0;
      data     = '0;
      notReady = 1'b0;
      for (int i = CANDS - 1; i >= 0; i--) begin
         if ((rs != 5'd0) && candVld[i] && (candRd[i*5 +: 5] == rs)) begin
            hit      = 1'b1;
            data     = candVal[i*XLEN +: XLEN];
            notReady = !candRdy[i];
         end
      end
   end

endmodule

// File: rtl/pipe_track.sv
// Chain of STAGES instruction slots with deep forwarding, load-use stalls, partial flush.
// Latency: fetch accepted at edge n sits in slot k after edge n+k; retires STAGES cycles later.
// Backpressure: fetch_ready drops whenever any slot holds; holding slots insert one bubble above.
module pipe_track
   import pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 4,
   localparam int FDW   = $clog2(STAGES + 1)
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     fetch_valid,
   input  logic [31:0]              fetch_instr,
   input  logic [XLEN-1:0]          fetch_pc,
   output logic                     fetch_ready,
   input  logic [STAGES-1:0]        stall_req,
   input  logic                     flush_req,
   input  logic [FDW-1:0]           flush_depth,
   input  logic [STAGES*XLEN-1:0]   res_data,
   input  logic [STAGES-1:0]        res_avail,
   output logic [STAGES-1:0]        slot_valid,
   output logic [STAGES*32-1:0]     slot_instr,
   output logic [STAGES*XLEN-1:0]   slot_pc,
   output logic [1:0]               fwd_hit,
   output logic [2*XLEN-1:0]        fwd_data,
   output logic                     hazard_stall,
   output logic                     retire_valid,
   output logic [31:0]              retire_count,
   output logic [31:0]              stall_count
);

   typedef struct packed {
      logic            valid;
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] result;
      logic            avail;
   } slot_t;

   localparam slot_t BUBBLE = '{valid: 1'b0, instr: NOP, pc: '0, result: '0, avail: 1'b0};

   // A result reported for a slot sticks to that instruction as it moves or holds
   function automatic slot_t latchRes(input slot_t s, input logic av, input logic [XLEN-1:0] d);
      slot_t r;
      r = s;
      if (av) begin
         r.result = d;
         r.avail  = 1'b1;
      end
      return r;
   endfunction

   slot_t slotQ [STAGES];
   slot_t slotD [STAGES];

   logic [STAGES-2:0]          candVld;
   logic [STAGES-2:0]          candRdy;
   logic [(STAGES-1)*5-1:0]    candRd;
   logic [(STAGES-1)*XLEN-1:0] candVal;

   logic            hit1, hit2, notRdy1, notRdy2;
   logic [XLEN-1:0] data1, data2;
   logic            hazard, anyStall;
   logic [STAGES-1:0] stallVec, holdMask, flushMask;
   logic [31:0]     retireCnt, stallCnt;

   // Present slots 1..STAGES-1 as forwarding candidates, live result taking priority
   always_comb begin
      candVld = '0;
      candRdy = '0;
      candRd  = '0;
      candVal = '0;
      for (int k = 1; k < STAGES; k++) begin
         candVld[k-1]               = slotQ[k].valid && writes_rd(slotQ[k].instr);
         candRd[(k-1)*5 +: 5]       = slotQ[k].instr[11:7];
         candVal[(k-1)*XLEN +: XLEN] = res_avail[k] ? res_data[k*XLEN +: XLEN] : slotQ[k].result;
         candRdy[k-1]               = res_avail[k] | slotQ[k].avail;
      end
   end

   pipe_fwd_select #(.XLEN(XLEN), .CANDS(STAGES-1)) uFwdRs1 (
      .rs       (slotQ[0].instr[19:15]),
      .candVld  (candVld),
      .candRd   (candRd),
      .candVal  (candVal),
      .candRdy  (candRdy),
      .hit      (hit1),
      .data     (data1),
      .notReady (notRdy1)
   );

   pipe_fwd_select #(.XLEN(XLEN), .CANDS(STAGES-1)) uFwdRs2 (
      .rs       (slotQ[0].instr[24:20]),
      .candVld  (candVld),
      .candRd   (candRd),
      .candVal  (candVal),
      .candRdy  (candRdy),
      .hit      (hit2),
      .data     (data2),
      .notReady (notRdy2)
   );

   assign hazard       = (hit1 & notRdy1) | (hit2 & notRdy2);
   assign hazard_stall = hazard;
   assign fwd_hit      = {hit2, hit1};
   assign fwd_data     = {data2, data1};

   // Every slot at or below the highest stall request holds; flush mask from slot 0 upward
   always_comb begin
      stallVec    = stall_req;
      stallVec[0] = stall_req[0] | hazard;
      holdMask    = '0;
      flushMask   = '0;
      for (int k = 0; k < STAGES; k++) begin
         holdMask[k]  = |(stallVec >> k);
         flushMask[k] = flush_req && (FDW'(k) < flush_depth);
      end
   end

   assign anyStall    = |stallVec;
   assign fetch_ready = !anyStall;

   // Next slot contents: flush beats hold, hold latches results, the first non-held slot gets a bubble
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         slotD[k] = slotQ[k];
      end
      if (flushMask[0]) begin
         slotD[0] = BUBBLE;
      end else if (holdMask[0]) begin
         slotD[0] = latchRes(slotQ[0], res_avail[0], res_data[0 +: XLEN]);
      end else if (fetch_valid) begin
         slotD[0].valid  = 1'b1;
         slotD[0].instr  = fetch_instr;
         slotD[0].pc     = fetch_pc;
         slotD[0].result = '0;
         slotD[0].avail  = 1'b0;
      end else begin
         slotD[0] = BUBBLE;
      end
      for (int k = 1; k < STAGES; k++) begin
         if (flushMask[k]) begin
            slotD[k] = BUBBLE;
         end else if (holdMask[k]) begin
            slotD[k] = latchRes(slotQ[k], res_avail[k], res_data[k*XLEN +: XLEN]);
         end else if (holdMask[k-1]) begin
            slotD[k] = BUBBLE;
         end else begin
            slotD[k] = latchRes(slotQ[k-1], res_avail[k-1], res_data[(k-1)*XLEN +: XLEN]);
         end
      end
   end

   // Slot registers and wrapping activity counters
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < STAGES; k++) begin
            slotQ[k] <= BUBBLE;
         end
         retireCnt <= '0;
         stallCnt  <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            slotQ[k] <= slotD[k];
         end
         if (retire_valid) begin
            retireCnt <= retireCnt + 32'd1;
         end
         if (anyStall) begin
            stallCnt <= stallCnt + 32'd1;
         end
      end
   end

   assign retire_valid = slotQ[STAGES-1].valid;
   assign retire_count = retireCnt;
   assign stall_count  = stallCnt;

   // Flatten slot state onto the datapath-facing buses
   always_comb begin
      slot_valid = '0;
      slot_instr = '0;
      slot_pc    = '0;
      for (int k = 0; k < STAGES; k++) begin
         slot_valid[k]            = slotQ[k].valid;
         slot_instr[k*32 +: 32]   = slotQ[k].instr;
         slot_pc[k*XLEN +: XLEN]  = slotQ[k].pc;
      end
   end

endmodule

// File: tb/tb_pipe_track.sv
`timescale 1ns/1ps
module tb_pipe_track;
   localparam int XLEN = 32;
   localparam int S    = 4;
   localparam int FDW  = $clog2(S + 1);
   localparam logic [31:0] NOPI = 32'h0000_0033;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              fetch_valid;
   logic [31:0]       fetch_instr;
   logic [XLEN-1:0]   fetch_pc;
   logic              fetch_ready;
   logic [S-1:0]      stall_req;
   logic              flush_req;
   logic [FDW-1:0]    flush_depth;
   logic [S*XLEN-1:0] res_data;
   logic [S-1:0]      res_avail;
   logic [S-1:0]      slot_valid;
   logic [S*32-1:0]   slot_instr;
   logic [S*XLEN-1:0] slot_pc;
   logic [1:0]        fwd_hit;
   logic [2*XLEN-1:0] fwd_data;
   logic              hazard_stall;
   logic              retire_valid;
   logic [31:0]       retire_count;
   logic [31:0]       stall_count;

   always #5 clock = ~clock;

   pipe_track #(.XLEN(XLEN), .STAGES(S)) dut (
      .clock(clock), .reset_n(reset_n),
      .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
      .fetch_ready(fetch_ready), .stall_req(stall_req), .flush_req(flush_req),
      .flush_depth(flush_depth), .res_data(res_data), .res_avail(res_avail),
      .slot_valid(slot_valid), .slot_instr(slot_instr), .slot_pc(slot_pc),
      .fwd_hit(fwd_hit), .fwd_data(fwd_data), .hazard_stall(hazard_stall),
      .retire_valid(retire_valid), .retire_count(retire_count), .stall_count(stall_count)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        mValid [S];
   logic [31:0] mInstr [S];
   logic [31:0] mPc    [S];
   logic [31:0] mRes   [S];
   logic        mAvail [S];
   logic [31:0] mRet, mStall;
   logic        mHit [2];
   logic [31:0] mFwd [2];
   logic        mHazard;
   int          mStallPt;

   function automatic bit producesRd(input logic [31:0] ins);
      logic [6:0] op;
      bit known;
      op = ins[6:0];
      known = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h6F) ||
              (op == 7'h67) || (op == 7'h37) || (op == 7'h17);
      return known && (ins[11:7] != 5'd0);
   endfunction

   task automatic modelReset();
      for (int k = 0; k < S; k++) begin
         mValid[k] = 1'b0; mInstr[k] = NOPI; mPc[k] = '0; mRes[k] = '0; mAvail[k] = 1'b0;
      end
      mRet = '0;
      mStall = '0;
   endtask

   // Forwarding result, hazard and highest stalled slot from model state and live inputs
   task automatic evalComb();
      logic [4:0] rs [2];
      bit found;
      rs[0] = mInstr[0][19:15];
      rs[1] = mInstr[0][24:20];
      mHazard = 1'b0;
      for (int r = 0; r < 2; r++) begin
         mHit[r] = 1'b0;
         mFwd[r] = '0;
         found = 0;
         if (rs[r] != 5'd0) begin
            for (int j = 1; j < S; j++) begin
               if (!found && mValid[j] && producesRd(mInstr[j]) && (mInstr[j][11:7] == rs[r])) begin
                  found = 1;
                  mHit[r] = 1'b1;
                  mFwd[r] = res_avail[j] ? res_data[j*32 +: 32] : mRes[j];
                  if (!res_avail[j] && !mAvail[j]) mHazard = 1'b1;
               end
            end
         end
      end
      mStallPt = -1;
      for (int k = 0; k < S; k++) begin
         if (stall_req[k] || (k == 0 && mHazard)) mStallPt = k;
      end
   endtask

   task automatic modelStep();
      logic        nV [S];
      logic [31:0] nI [S];
      logic [31:0] nP [S];
      logic [31:0] nR [S];
      logic        nA [S];
      evalComb();
      if (mValid[S-1]) mRet = mRet + 1;
      if (mStallPt >= 0) mStall = mStall + 1;
      for (int k = 0; k < S; k++) begin
         nV[k] = 1'b0; nI[k] = NOPI; nP[k] = '0; nR[k] = '0; nA[k] = 1'b0;
         if (flush_req && k < int'(flush_depth)) begin
            // bubble
         end else if (k <= mStallPt) begin
            nV[k] = mValid[k]; nI[k] = mInstr[k]; nP[k] = mPc[k];
            nR[k] = res_avail[k] ? res_data[k*32 +: 32] : mRes[k];
            nA[k] = res_avail[k] | mAvail[k];
         end else if (k == 0) begin
            if (fetch_valid) begin
               nV[0] = 1'b1; nI[0] = fetch_instr; nP[0] = fetch_pc;
            end
         end else if (k == mStallPt + 1) begin
            // bubble above the stall point
         end else begin
            nV[k] = mValid[k-1]; nI[k] = mInstr[k-1]; nP[k] = mPc[k-1];
            nR[k] = res_avail[k-1] ? res_data[(k-1)*32 +: 32] : mRes[k-1];
            nA[k] = res_avail[k-1] | mAvail[k-1];
         end
      end
      for (int k = 0; k < S; k++) begin
         mValid[k] = nV[k]; mInstr[k] = nI[k]; mPc[k] = nP[k]; mRes[k] = nR[k]; mAvail[k] = nA[k];
      end
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) modelReset();
      else modelStep();
   end

   // Compare every output against the model once per cycle
   always @(negedge clock) begin
      if (reset_n) begin : cmp
         logic [S-1:0]    eV;
         logic [S*32-1:0] eI, eP, aP;
         evalComb();
         for (int k = 0; k < S; k++) begin
            eV[k] = mValid[k];
            eI[k*32 +: 32] = mInstr[k];
            eP[k*32 +: 32] = mValid[k] ? mPc[k] : 32'd0;
            aP[k*32 +: 32] = mValid[k] ? slot_pc[k*32 +: 32] : 32'd0;
         end
         check("slot_valid", slot_valid, eV);
         check("slot_instr", slot_instr, eI);
         check("slot_pc", aP, eP);
         check("fwd_hit", fwd_hit, {mHit[1], mHit[0]});
         for (int r = 0; r < 2; r++) begin
            if (mHit[r]) check("fwd_data", fwd_data[r*32 +: 32], mFwd[r]);
         end
         check("hazard_stall", hazard_stall, mHazard);
         check("fetch_ready", fetch_ready, (mStallPt < 0));
         check("retire_valid", retire_valid, mValid[S-1]);
         check("retire_count", retire_count, mRet);
         check("stall_count", stall_count, mStall);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] encAddi(input int rd, input int imm);
      logic [31:0] v;
      v = {12'(imm), 5'd0, 3'd0, 5'(rd), 7'h13};
      return v;
   endfunction

   function automatic logic [31:0] encAdd(input int rd, input int rs1, input int rs2);
      logic [31:0] v;
      v = {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
      return v;
   endfunction

   function automatic logic [31:0] encLw(input int rd);
      logic [31:0] v;
      v = {12'd0, 5'd0, 3'd2, 5'(rd), 7'h03};
      return v;
   endfunction

   function automatic logic [31:0] randInstr();
      logic [31:0] v;
      v = $urandom();
      case ($urandom_range(0, 6))
         0: v[6:0] = 7'h33;
         1: v[6:0] = 7'h13;
         2: v[6:0] = 7'h03;
         3: v[6:0] = 7'h23;
         4: v[6:0] = 7'h63;
         5: v[6:0] = 7'h37;
         default: v[6:0] = 7'h6F;
      endcase
      v[11:7]  = 5'($urandom_range(0, 5));
      v[19:15] = 5'($urandom_range(0, 5));
      v[24:20] = 5'($urandom_range(0, 5));
      return v;
   endfunction

   task automatic idle();
      fetch_valid = 1'b0; fetch_instr = NOPI; fetch_pc = '0;
      stall_req = '0; flush_req = 1'b0; flush_depth = '0;
      res_avail = '0; res_data = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      fetch_valid = 1'b1; fetch_instr = ins; fetch_pc = pc;
   endtask

   task automatic doReset();
      idle();
      reset_n = 1'b0;
      #1;
      check("rst slot_valid", slot_valid, '0);
      check("rst slot_instr", slot_instr, {S{NOPI}});
      check("rst slot_pc", slot_pc, '0);
      check("rst retire_count", retire_count, 32'd0);
      check("rst stall_count", stall_count, 32'd0);
      check("rst fetch_ready", fetch_ready, 1'b1);
      check("rst hazard_stall", hazard_stall, 1'b0);
      check("rst fwd_hit", fwd_hit, 2'b00);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic fill(input logic [31:0] base);
      for (int i = 0; i < S; i++) begin
         drive(encAddi(i + 1, 0), base + 32'(4 * i));
         tick();
      end
      idle();
   endtask

   initial begin
      reset_n = 1'b1;
      idle();
      #2;

      // 1: six addi stream through, one slot per cycle
      doReset();
      for (int i = 0; i < 6; i++) begin
         drive(encAddi(i + 1, 32 * (i + 1)), 32'(4 * i));
         tick();
         if (i == 0) check("t1 slot0 pc", slot_pc[31:0], 32'h0);
         if (i == 2) check("t1 slot2 pc", slot_pc[95:64], 32'h0);
         if (i == 2) check("t1 slot0 pc", slot_pc[31:0], 32'h8);
      end
      idle();
      repeat (4) tick();
      check("t1 retire_count", retire_count, 32'd6);

      // 2: youngest producer wins, then the latched copy serves a later reader
      doReset();
      drive(encAdd(3, 1, 2), 32'h40); tick();
      drive(encAdd(3, 4, 5), 32'h44); tick();
      drive(encAdd(6, 3, 0), 32'h48); tick();
      drive(encAdd(8, 3, 0), 32'h4C);
      res_avail = 4'b0110;
      res_data[63:32] = 32'd9;
      res_data[95:64] = 32'd7;
      @(negedge clock);
      check("t2 fwd_hit", fwd_hit, 2'b01);
      check("t2 fwd_data", fwd_data[31:0], 32'd9);
      tick();
      idle();
      @(negedge clock);
      check("t2 latched fwd_hit", fwd_hit, 2'b01);
      check("t2 latched fwd_data", fwd_data[31:0], 32'd9);
      check("t2 latched hazard", hazard_stall, 1'b0);
      tick();

      // 3: load-use stall, one bubble, resume on the following cycle
      doReset();
      drive(encLw(5), 32'h80); tick();
      drive(encAdd(7, 5, 0), 32'h84); tick();
      idle();
      @(negedge clock);
      check("t3 hazard_stall", hazard_stall, 1'b1);
      check("t3 fetch_ready", fetch_ready, 1'b0);
      tick();
      check("t3 slot_valid", slot_valid, 4'b0101);
      check("t3 slot1 instr", slot_instr[63:32], NOPI);
      check("t3 slot0 pc", slot_pc[31:0], 32'h84);
      check("t3 stall_count", stall_count, 32'd1);
      res_avail = 4'b0100;
      res_data[95:64] = 32'h55;
      @(negedge clock);
      check("t3 resume hazard", hazard_stall, 1'b0);
      check("t3 resume fwd_data", fwd_data[31:0], 32'h55);
      check("t3 resume fetch_ready", fetch_ready, 1'b1);
      tick();
      idle();

      // 4: flush depth 2 over a stall at slot 1
      doReset();
      fill(32'h100);
      drive(encAddi(9, 0), 32'h110);
      stall_req = 4'b0010;
      flush_req = 1'b1;
      flush_depth = 3'd2;
      @(negedge clock);
      check("t4 fetch_ready", fetch_ready, 1'b0);
      tick();
      idle();
      check("t4 slot_valid", slot_valid, 4'b1000);
      check("t4 slot3 pc", slot_pc[127:96], 32'h104);
      check("t4 low instr", slot_instr[63:0], {NOPI, NOPI});

      // 5: stall at the oldest slot freezes the whole chain
      doReset();
      fill(32'h200);
      drive(encAddi(9, 0), 32'h210);
      stall_req = 4'b1000;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t5 slot_valid", slot_valid, 4'b1111);
         check("t5 slot_pc", slot_pc, {32'h200, 32'h204, 32'h208, 32'h20C});
         check("t5 retire_valid", retire_valid, 1'b1);
      end
      idle();
      check("t5 stall_count", stall_count, 32'd3);

      // 6: asynchronous reset mid-stream
      doReset();
      fill(32'h300);
      check("t6 full", slot_valid, 4'b1111);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6 slot_valid", slot_valid, '0);
      check("t6 slot_instr", slot_instr, {S{NOPI}});
      check("t6 retire_count", retire_count, 32'd0);
      check("t6 stall_count", stall_count, 32'd0);
      check("t6 fetch_ready", fetch_ready, 1'b1);
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Random traffic against the model
      doReset();
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] pcRaw;
         pcRaw = $urandom();
         fetch_valid = ($urandom_range(0, 9) < 8);
         fetch_instr = randInstr();
         fetch_pc    = {pcRaw[31:2], 2'b00};
         for (int k = 0; k < S; k++) stall_req[k] = ($urandom_range(0, 19) == 0);
         flush_req   = ($urandom_range(0, 24) == 0);
         flush_depth = FDW'($urandom_range(0, S));
         res_avail   = S'($urandom());
         res_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
         tick();
      end
      idle();
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
